// File: rtl/buzz_round_if.sv
// Host/contestant-side signal bundle for the quiz buzzer round controller.
// master = host side (drives strobes and buttons), slave = controller side.
interface buzz_round_if;
  logic       tick;
  logic       start;
  logic       stop;
  logic       clear;
  logic [3:0] k;
  logic [2:0] state;
  logic [2:0] winner;
  logic [3:0] lamp;
  logic [5:0] time_left;
  logic [3:0] foul_mask;
  logic       buzzer;

  modport master (
    output tick, start, stop, clear, k,
    input  state, winner, lamp, time_left, foul_mask, buzzer
  );

  modport slave (
    input  tick, start, stop, clear, k,
    output state, winner, lamp, time_left, foul_mask, buzzer
  );
endinterface

// File: rtl/buzz_round_ctrl.sv
// Quiz buzzer round controller: arms a round, latches the first press,
// flags early presses as fouls, runs the answer countdown and drives
// the lamps and the buzzer. All outputs are registered.
// Optional feature: define BUZZ_FOUL_LOCKOUT_EN to exclude fouling
// groups from arbitration in the following ARMED phase.
module buzz_round_ctrl #(
  parameter int ANSWER_SECS = 30
) (
  input logic         clk,
  input logic         reset,
  buzz_round_if.slave bus
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARMED   = 3'd1;
  localparam logic [2:0] ST_ANSWER  = 3'd2;
  localparam logic [2:0] ST_DONE    = 3'd3;
  localparam logic [2:0] ST_TIMEOUT = 3'd4;

  localparam logic [5:0] LP_SECS = 6'(ANSWER_SECS);

  logic [2:0] r_state, w_state_next;
  logic [2:0] r_winner, w_winner_next;
  logic [3:0] r_lamp, w_lamp_next;
  logic [5:0] r_time_left, w_time_left_next;
  logic [3:0] r_foul_mask, w_foul_mask_next;
  logic       r_buzzer, w_buzzer_next;

  logic [3:0] w_eligible;
  logic [1:0] w_win_idx;
  logic       w_any_press;

`ifdef BUZZ_FOUL_LOCKOUT_EN
  assign w_eligible = bus.k & ~r_foul_mask;
`else
  assign w_eligible = bus.k;
`endif

  assign w_any_press = |w_eligible;

  // Priority encoder: lowest set index wins (group 1 beats all on a tie)
  always_comb begin
    w_win_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_eligible[i]) w_win_idx = 2'(i);
    end
  end

  // Next-state and next-output computation; clear overrides everything
  always_comb begin
    w_state_next     = r_state;
    w_winner_next    = r_winner;
    w_lamp_next      = r_lamp;
    w_time_left_next = r_time_left;
    w_foul_mask_next = r_foul_mask;
    w_buzzer_next    = 1'b0;
    if (bus.clear) begin
      w_state_next     = ST_IDLE;
      w_winner_next    = 3'd0;
      w_lamp_next      = 4'b1111;
      w_time_left_next = 6'd0;
      w_foul_mask_next = 4'b0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // A press here is a foul even on the start edge itself
          w_foul_mask_next = r_foul_mask | bus.k;
          w_buzzer_next    = |(bus.k & ~r_foul_mask);
          if (bus.start) w_state_next = ST_ARMED;
        end
        ST_ARMED: begin
          if (w_any_press) begin
            w_winner_next    = {1'b0, w_win_idx} + 3'd1;
            w_lamp_next      = ~(4'b0001 << w_win_idx);
            w_time_left_next = LP_SECS;
            w_state_next     = ST_ANSWER;
          end
        end
        ST_ANSWER: begin
          if (bus.stop) begin
            w_state_next = ST_DONE;
          end else if (bus.tick) begin
            if (r_time_left <= 6'd1) begin
              w_time_left_next = 6'd0;
              w_state_next     = ST_TIMEOUT;
              w_buzzer_next    = 1'b1;
            end else begin
              w_time_left_next = r_time_left - 6'd1;
            end
          end
        end
        ST_DONE: begin
        end
        ST_TIMEOUT: begin
          w_buzzer_next = 1'b1;
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_winner    <= 3'd0;
      r_lamp      <= 4'b1111;
      r_time_left <= 6'd0;
      r_foul_mask <= 4'b0000;
      r_buzzer    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_winner    <= w_winner_next;
      r_lamp      <= w_lamp_next;
      r_time_left <= w_time_left_next;
      r_foul_mask <= w_foul_mask_next;
      r_buzzer    <= w_buzzer_next;
    end
  end

  assign bus.state     = r_state;
  assign bus.winner    = r_winner;
  assign bus.lamp      = r_lamp;
  assign bus.time_left = r_time_left;
  assign bus.foul_mask = r_foul_mask;
  assign bus.buzzer    = r_buzzer;

endmodule

// File: tb/tb_buzz_round_ctrl.sv
// Bench for buzz_round_ctrl (ANSWER_SECS=3). Each transaction pushes its
// expected outputs into a queue when driven; after the clock edge the
// entry is popped and compared against the registered outputs.
module tb_buzz_round_ctrl;

  localparam int SECS = 3;
`ifdef BUZZ_FOUL_LOCKOUT_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] win;
    logic [3:0] lamp;
    logic [5:0] tl;
    logic [3:0] fm;
    logic       bz;
  } exp_t;

  logic clk;
  logic reset;
  buzz_round_if bus();

  exp_t exp_q[$];
  int n_vec;
  int n_err;
  int n_txn;

  buzz_round_ctrl #(.ANSWER_SECS(SECS)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL txn %0d %s: got %0h expected %0h", n_txn, tag, obs, exp_v);
    end
  endtask

  // Drive one cycle of stimulus and queue the outputs expected after the edge
  task automatic apply(input logic rst, input logic tk, input logic st, input logic sp,
                       input logic cl, input logic [3:0] kk,
                       input logic [2:0] e_st, input logic [2:0] e_win,
                       input logic [3:0] e_lamp, input logic [5:0] e_tl,
                       input logic [3:0] e_fm, input logic e_bz);
    exp_t e;
    exp_t p;
    @(negedge clk);
    reset     = rst;
    bus.tick  = tk;
    bus.start = st;
    bus.stop  = sp;
    bus.clear = cl;
    bus.k     = kk;
    e.st = e_st; e.win = e_win; e.lamp = e_lamp; e.tl = e_tl; e.fm = e_fm; e.bz = e_bz;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    n_txn++;
    p = exp_q.pop_front();
    chk("state",     8'(bus.state),     8'(p.st));
    chk("winner",    8'(bus.winner),    8'(p.win));
    chk("lamp",      8'(bus.lamp),      8'(p.lamp));
    chk("time_left", 8'(bus.time_left), 8'(p.tl));
    chk("foul_mask", 8'(bus.foul_mask), 8'(p.fm));
    chk("buzzer",    8'(bus.buzzer),    8'(p.bz));
    $display("txn %0d: rst=%b tick=%b start=%b stop=%b clear=%b k=%b -> state=%0d winner=%0d lamp=%b time_left=%0d foul_mask=%b buzzer=%b",
             n_txn, rst, tk, st, sp, cl, kk, bus.state, bus.winner, bus.lamp,
             bus.time_left, bus.foul_mask, bus.buzzer);
  endtask

  initial begin
    n_vec = 0; n_err = 0; n_txn = 0;
    reset = 1'b1;
    bus.tick = 0; bus.start = 0; bus.stop = 0; bus.clear = 0; bus.k = 4'b0000;

    //     rst tk st sp cl k         state win lamp     tl         fm       bz
    apply(1, 0, 0, 0, 0, 4'b0000,  3'd0, 3'd0, 4'b1111, 6'd0,     4'b0000, 0);
    // Basic win by group 3, later press ignored
    apply(0, 0, 1, 0, 0, 4'b0000,  3'd1, 3'd0, 4'b1111, 6'd0,     4'b0000, 0);
    apply(0, 0, 0, 0, 0, 4'b0100,  3'd2, 3'd3, 4'b1011, 6'(SECS), 4'b0000, 0);
    apply(0, 0, 0, 0, 0, 4'b0001,  3'd2, 3'd3, 4'b1011, 6'(SECS), 4'b0000, 0);
    apply(0, 0, 0, 0, 1, 4'b0000,  3'd0, 3'd0, 4'b1111, 6'd0,     4'b0000, 0);
    // Same-edge tie, then tick, stop, held through tick, start ignored in DONE
    apply(0, 0, 1, 0, 0, 4'b0000,  3'd1, 3'd0, 4'b1111, 6'd0,     4'b0000, 0);
    apply(0, 0, 0, 0, 0, 4'b1010,  3'd2, 3'd2, 4'b1101, 6'(SECS), 4'b0000, 0);
    apply(0, 0, 0, 0, 0, 4'b0001,  3'd2, 3'd2, 4'b1101, 6'(SECS), 4'b0000, 0);
    apply(0, 1, 0, 0, 0, 4'b0000,  3'd2, 3'd2, 4'b1101, 6'(SECS-1), 4'b0000, 0);
    apply(0, 0, 0, 1, 0, 4'b0000,  3'd3, 3'd2, 4'b1101, 6'(SECS-1), 4'b0000, 0);
    apply(0, 1, 0, 0, 0, 4'b0000,  3'd3, 3'd2, 4'b1101, 6'(SECS-1), 4'b0000, 0);
    apply(0, 0, 1, 0, 0, 4'b0000,  3'd3, 3'd2, 4'b1101, 6'(SECS-1), 4'b0000, 0);
    apply(0, 0, 0, 0, 1, 4'b0000,  3'd0, 3'd0, 4'b1111, 6'd0,     4'b0000, 0);
    // Foul by group 1: one-cycle buzzer, then lockout-dependent arbitration
    apply(0, 0, 0, 0, 0, 4'b0001,  3'd0, 3'd0, 4'b1111, 6'd0,     4'b0001, 1);
    apply(0, 0, 0, 0, 0, 4'b0001,  3'd0, 3'd0, 4'b1111, 6'd0,     4'b0001, 0);
    apply(0, 0, 1, 0, 0, 4'b0000,  3'd1, 3'd0, 4'b1111, 6'd0,     4'b0001, 0);
    apply(0, 0, 0, 0, 0, 4'b0011,  3'd2, LOCK ? 3'd2 : 3'd1, LOCK ? 4'b1101 : 4'b1110,
          6'(SECS), 4'b0001, 0);
    // Countdown to timeout
    apply(0, 1, 0, 0, 0, 4'b0000,  3'd2, LOCK ? 3'd2 : 3'd1, LOCK ? 4'b1101 : 4'b1110,
          6'd2, 4'b0001, 0);
    apply(0, 1, 0, 0, 0, 4'b0000,  3'd2, LOCK ? 3'd2 : 3'd1, LOCK ? 4'b1101 : 4'b1110,
          6'd1, 4'b0001, 0);
    apply(0, 1, 0, 0, 0, 4'b0000,  3'd4, LOCK ? 3'd2 : 3'd1, LOCK ? 4'b1101 : 4'b1110,
          6'd0, 4'b0001, 1);
    apply(0, 1, 0, 0, 0, 4'b0000,  3'd4, LOCK ? 3'd2 : 3'd1, LOCK ? 4'b1101 : 4'b1110,
          6'd0, 4'b0001, 1);
    apply(0, 0, 0, 0, 1, 4'b0000,  3'd0, 3'd0, 4'b1111, 6'd0,     4'b0000, 0);
    // Tick on arbitration edge is not counted; stop beats final tick
    apply(0, 0, 1, 0, 0, 4'b0000,  3'd1, 3'd0, 4'b1111, 6'd0,     4'b0000, 0);
    apply(0, 1, 0, 0, 0, 4'b1000,  3'd2, 3'd4, 4'b0111, 6'(SECS), 4'b0000, 0);
    apply(0, 1, 0, 0, 0, 4'b0000,  3'd2, 3'd4, 4'b0111, 6'd2,     4'b0000, 0);
    apply(0, 1, 0, 0, 0, 4'b0000,  3'd2, 3'd4, 4'b0111, 6'd1,     4'b0000, 0);
    apply(0, 1, 0, 1, 0, 4'b0000,  3'd3, 3'd4, 4'b0111, 6'd1,     4'b0000, 0);
    apply(0, 0, 0, 0, 1, 4'b0000,  3'd0, 3'd0, 4'b1111, 6'd0,     4'b0000, 0);
    // Reset in ANSWER together with clear and tick
    apply(0, 0, 1, 0, 0, 4'b0000,  3'd1, 3'd0, 4'b1111, 6'd0,     4'b0000, 0);
    apply(0, 0, 0, 0, 0, 4'b0010,  3'd2, 3'd2, 4'b1101, 6'(SECS), 4'b0000, 0);
    apply(1, 1, 0, 0, 1, 4'b0001,  3'd0, 3'd0, 4'b1111, 6'd0,     4'b0000, 0);
    // All four groups foul: lockout keeps ARMED, otherwise group 1 wins
    apply(0, 0, 0, 0, 0, 4'b1111,  3'd0, 3'd0, 4'b1111, 6'd0,     4'b1111, 1);
    apply(0, 0, 1, 0, 0, 4'b1111,  3'd1, 3'd0, 4'b1111, 6'd0,     4'b1111, 0);
    apply(0, 0, 0, 0, 0, 4'b1111,  LOCK ? 3'd1 : 3'd2, LOCK ? 3'd0 : 3'd1,
          LOCK ? 4'b1111 : 4'b1110, LOCK ? 6'd0 : 6'(SECS), 4'b1111, 0);
    apply(0, 0, 0, 0, 1, 4'b0000,  3'd0, 3'd0, 4'b1111, 6'd0,     4'b0000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule

// File: doc/buzz_round_ctrl.md
# buzz_round_ctrl

Round controller and first-press arbiter for the four-contestant quiz buzzer. It arms a round on the host's command and latches exactly one winner. It flags early presses as fouls, runs the per-answer countdown and drives the contestant lamps and the buzzer. Its winner code and countdown feed the 7-segment decoders and the LCD line builder; the score keeper samples its `winner` and `state` outputs.

## Interface

Parameters:
- `ANSWER_SECS`, default 30: answer window in seconds; legal range 1..63.

Ports:
- `clk`  in  1: system clock; single clock domain.
- `reset`  in  1: synchronous, active-high.
- `tick`  in  1: one-`clk`-cycle strobe, once per second.
- `start`  in  1: host "go" pulse; accepted only in IDLE.
- `stop`  in  1: host "answer given" pulse; accepted only in ANSWER.
- `clear`  in  1: host "end round" pulse; accepted in every state.
- `k`  in  4: contestant buttons, level, active-high, already synchronized. `k[0]` is group 1.
- `state`  out  3: IDLE=0, ARMED=1, ANSWER=2, DONE=3, TIMEOUT=4.
- `winner`  out  3: 0 = none, 1..4 = group number.
- `lamp`  out  4: active-low; `lamp[i]` = 0 when group i+1 is the winner.
- `time_left`  out  6: remaining answer seconds, unsigned binary.
- `foul_mask`  out  4: groups that pressed while IDLE.
- `buzzer`  out  1: active-high sounder enable.

## Operation

- Reset values: `state`=IDLE, `winner`=0, `lamp`=4'b1111, `time_left`=0, `foul_mask`=0, `buzzer`=0. All outputs are registered.
- IDLE: for any i with `k[i]`=1, `foul_mask[i]` is set (sticky). `start` moves the FSM to ARMED.
- ARMED: eligible = `k & ~foul_mask` when lockout is compiled in, otherwise `k`. If any bit of eligible is set:
  - the lowest set index wins (group 1 has highest priority on a same-cycle tie);
  - `winner` is loaded, the matching `lamp` bit is cleared, `time_left` is set to ANSWER_SECS, and the FSM moves to ANSWER.
- ANSWER: presses from other groups are ignored.
  - `stop` moves to DONE with `time_left` frozen.
  - A `tick` with `time_left`=1 sets it to 0 and moves to TIMEOUT.
  - Any other `tick` decrements `time_left` by 1.
- DONE / TIMEOUT: hold `winner`, `lamp` and `time_left` until `clear`.
- `clear` from any state moves to IDLE and zeroes `winner`, `time_left` and `foul_mask`; `lamp` returns to 4'b1111.
- `buzzer` = 1 in IDLE while `(k & ~foul_mask_prev)` != 0, i.e. for exactly one cycle per newly fouling group. `buzzer` is also 1 continuously in TIMEOUT.
- Priority within a cycle: `reset` > `clear` > `stop`/timeout > `start` / arbitration.
- `start` outside IDLE, and `stop` outside ANSWER, are ignored.
- If all four groups are locked out, ARMED persists until `clear`.

## Timing

- Press-to-winner latency: `k` sampled high on edge N gives `winner`/`lamp` valid after edge N, i.e. in cycle N+1.
- `start` on edge N: ARMED from cycle N+1. A press sampled on edge N is treated as an IDLE foul, not as an entry.
- `tick` coincident with the arbitration edge: it is not counted; countdown starts on the next tick.
- `stop` and final `tick` on the same edge: `stop` wins, giving DONE with `time_left`=1.
- `clear` is 1-cycle: IDLE and reset outputs from the next cycle.
- `reset` mid-round has the same effect as `clear`, plus it also forces `buzzer`=0.

## Configuration

- `BUZZ_FOUL_LOCKOUT_EN` defined: groups in `foul_mask` are excluded from arbitration for the next round.
- Not defined: `foul_mask` and `buzzer` still report fouls, but all groups are eligible in ARMED.

## Test plan

- Reset, then `start`, then `k`=4'b0100 → `winner`=3, `lamp`=4'b1011, `time_left`=ANSWER_SECS, `state`=ANSWER one cycle later.
- ARMED with `k`=4'b1010 on the same edge → `winner`=2; a later `k`=4'b0001 leaves `winner`=2.
- IDLE press `k`=4'b0001 → `foul_mask`=0001, one-cycle `buzzer`. Then `start` and `k`=4'b0011:
  - with `BUZZ_FOUL_LOCKOUT_EN`: `winner`=2;
  - without: `winner`=1.
- ANSWER_SECS=3, win, then 3 ticks → `time_left` goes 2,1,0, `state`=TIMEOUT, `buzzer`=1; `clear` → IDLE, `buzzer`=0, `winner`=0.
- Win, 1 tick, then `stop` → DONE, `time_left`=ANSWER_SECS-1 held through further ticks. `start` in DONE is ignored.
- `reset` asserted in ANSWER with `clear` and `tick` also active → all outputs equal reset values the next cycle.
